lfst: RTL

Last Fetched Store Table for store-set memory dependence prediction; it consumes the 7-bit store set IDs (SSIDs) produced by the SSIT during rename. For each renamed memory instruction with a valid SSID, the block returns the tag of the most recent in-flight store in the same store set. Renamed stores record themselves as the new last store of their set. Issued stores and pipeline flushes retire entries. It sits in the rename stage beside the SSIT, and its dependence outputs feed the issue queue wakeup logic.

---
 rtl/lfst.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lfst.sv
// Last Fetched Store Table: per store set, the tag of the youngest in-flight
// store; four rename slots, intra-group bypass, issue-side retire/masking.
//
// Ports: clock, reset_n (async, active-low)
//   ren_v/ssid_v/ssid/st/tag{0..3}_in : rename group, slot 0 oldest
//   iss_v/ssid/tag_in                 : store issue (retires matching entry)
//   flush_in                          : clears every valid bit at next edge
//   dep_v/dep_tag{0..3}_out           : predicted producer store per slot
// Optional: LFST_CYCLIC_CLEAR_EN adds a CLR_LOG2-bit free-running counter
//   whose wrap clears the table, bounding the life of stale predictions.
module lfst #(
  parameter int TAG_W    = 7,
  parameter int CLR_LOG2 = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ren_v0_in,
  input  logic             ren_v1_in,
  input  logic             ren_v2_in,
  input  logic             ren_v3_in,
  input  logic             ren_ssid_v0_in,
  input  logic             ren_ssid_v1_in,
  input  logic             ren_ssid_v2_in,
  input  logic             ren_ssid_v3_in,
  input  logic [6:0]       ren_ssid0_in,
  input  logic [6:0]       ren_ssid1_in,
  input  logic [6:0]       ren_ssid2_in,
  input  logic [6:0]       ren_ssid3_in,
  input  logic             ren_st0_in,
  input  logic             ren_st1_in,
  input  logic             ren_st2_in,
  input  logic             ren_st3_in,
  input  logic [TAG_W-1:0] ren_tag0_in,
  input  logic [TAG_W-1:0] ren_tag1_in,
  input  logic [TAG_W-1:0] ren_tag2_in,
  input  logic [TAG_W-1:0] ren_tag3_in,
  input  logic             iss_v_in,
  input  logic [6:0]       iss_ssid_in,
  input  logic [TAG_W-1:0] iss_tag_in,
  input  logic             flush_in,
  output logic             dep_v0_out,
  output logic             dep_v1_out,
  output logic             dep_v2_out,
  output logic             dep_v3_out,
  output logic [TAG_W-1:0] dep_tag0_out,
  output logic [TAG_W-1:0] dep_tag1_out,
  output logic [TAG_W-1:0] dep_tag2_out,
  output logic [TAG_W-1:0] dep_tag3_out
);

  logic [3:0]       w_rv;
  logic [3:0]       w_sv;
  logic [3:0]       w_st;
  logic [3:0]       w_look;
  logic [3:0]       w_wr;
  logic [6:0]       w_ssid [4];
  logic [TAG_W-1:0] w_tag  [4];

  logic [127:0]     r_vld;
  logic [TAG_W-1:0] r_tag  [128];

  logic             w_wrap;
  logic             w_inv;

  logic [3:0]       w_byp;
  logic [TAG_W-1:0] w_btag [4];
  logic [3:0]       w_hit;
  logic [3:0]       w_dep_v;
  logic [TAG_W-1:0] w_dep_tag [4];

  assign w_rv = {ren_v3_in, ren_v2_in, ren_v1_in, ren_v0_in};
  assign w_sv = {ren_ssid_v3_in, ren_ssid_v2_in,
                 ren_ssid_v1_in, ren_ssid_v0_in};
  assign w_st = {ren_st3_in, ren_st2_in, ren_st1_in, ren_st0_in};

  assign w_ssid[0] = ren_ssid0_in;
  assign w_ssid[1] = ren_ssid1_in;
  assign w_ssid[2] = ren_ssid2_in;
  assign w_ssid[3] = ren_ssid3_in;
  assign w_tag[0]  = ren_tag0_in;
  assign w_tag[1]  = ren_tag1_in;
  assign w_tag[2]  = ren_tag2_in;
  assign w_tag[3]  = ren_tag3_in;

  assign w_look = w_rv & w_sv;
  assign w_wr   = w_look & w_st;

  // Only the store that owns the entry may retire it; an older issue with
  // a stale tag leaves a younger store's entry alone.
  assign w_inv = iss_v_in && (r_tag[iss_ssid_in] == iss_tag_in);

`ifdef LFST_CYCLIC_CLEAR_EN
  logic [CLR_LOG2-1:0] r_clr_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_cnt <= '0;
    end else begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Clear on the edge that takes the counter from all-ones back to 0.
  assign w_wrap = &r_clr_cnt;
`else
  assign w_wrap = 1'b0 && (CLR_LOG2 > 0);
`endif

  // Later statements win: rename writes override the issue invalidate,
  // and the highest slot writing an SSID wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
    end else if (flush_in || w_wrap) begin
      r_vld <= '0;
    end else begin
      if (w_inv) begin
        r_vld[iss_ssid_in] <= 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        if (w_wr[k]) begin
          r_vld[w_ssid[k]] <= 1'b1;
        end
      end
    end
  end

  // Tags carry no meaning without their valid bit, so they need no reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (w_wr[k]) begin
        r_tag[w_ssid[k]] <= w_tag[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_byp[k]     = 1'b0;
      w_btag[k]    = '0;
      w_hit[k]     = 1'b0;
      w_dep_v[k]   = 1'b0;
      w_dep_tag[k] = '0;
      // Youngest older store in the group with the same SSID wins.
      for (int j = 0; j < 4; j++) begin
        if (j < k && w_wr[j] && (w_ssid[j] == w_ssid[k])) begin
          w_byp[k]  = 1'b1;
          w_btag[k] = w_tag[j];
        end
      end
      // A table producer issuing this cycle no longer needs to be waited on.
      w_hit[k] = r_vld[w_ssid[k]] &&
                 !(iss_v_in && (r_tag[w_ssid[k]] == iss_tag_in));
      if (w_look[k]) begin
        if (w_byp[k]) begin
          w_dep_v[k]   = 1'b1;
          w_dep_tag[k] = w_btag[k];
        end else if (w_hit[k]) begin
          w_dep_v[k]   = 1'b1;
          w_dep_tag[k] = r_tag[w_ssid[k]];
        end
      end
    end
  end

  assign dep_v0_out   = w_dep_v[0];
  assign dep_v1_out   = w_dep_v[1];
  assign dep_v2_out   = w_dep_v[2];
  assign dep_v3_out   = w_dep_v[3];
  assign dep_tag0_out = w_dep_tag[0];
  assign dep_tag1_out = w_dep_tag[1];
  assign dep_tag2_out = w_dep_tag[2];
  assign dep_tag3_out = w_dep_tag[3];

endmodule
